// File: rtl/kd_query_scheduler_pkg.sv
// kd_sched_pkg: shared types and defaults for the KD-tree query scheduler.
package kd_sched_pkg;
    localparam int NUM_NODES_DEF = 63;
    localparam int TAG_W = 12;
    localparam int ADDR_W = 8;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_QUERY, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic v;
        logic [TAG_W-1:0] tag;
    } lane_tag_t;

    typedef struct packed {
        logic [ADDR_W-1:0] leaf;
        logic [TAG_W-1:0] tag;
    } result_t;
endpackage

// File: rtl/kd_result_fifo.sv
// kd_result_fifo: dual-push (A before B), single-pop result FIFO with occupancy count.
module kd_result_fifo
    import kd_sched_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_a,
    input  result_t                din_a,
    input  logic                   push_b,
    input  result_t                din_b,
    input  logic                   pop,
    output result_t                dout,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    result_t mem [DEPTH];
    logic [AW-1:0] wr, rd;

    assign dout = mem[rd];

    always_ff @(posedge clk) begin
        if (push_a) mem[wr] <= din_a;
        if (push_b) mem[wr + AW'(push_a)] <= din_b;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr <= '0;
            rd <= '0;
            count <= '0;
        end else begin
            wr <= wr + AW'(push_a) + AW'(push_b);
            if (pop) rd <= rd + AW'(1);
            count <= count + (AW+1)'(push_a) + (AW+1)'(push_b) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/kd_query_scheduler.sv
// kd_query_scheduler: loads the KD tree, pairs queries onto its two lanes, collects tagged leaves.
// Define KD_SCHED_PERF_EN to enable the perf_cycles/perf_stalls counters.
module kd_query_scheduler
    import kd_sched_pkg::*;
#(
    parameter int INTERNAL_WIDTH = 22,
    parameter int PATCH_WIDTH = 55,
    parameter int ADDRESS_WIDTH = ADDR_W,
    parameter int TAG_WIDTH = TAG_W,
    parameter int NUM_NODES = NUM_NODES_DEF,
    parameter int TREE_LATENCY = 7,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      skip_load,
    input  logic [TAG_WIDTH-1:0]      num_queries,
    input  logic                      node_valid,
    output logic                      node_ready,
    input  logic [INTERNAL_WIDTH-1:0] node_data,
    input  logic                      q_valid,
    output logic                      q_ready,
    input  logic [PATCH_WIDTH-1:0]    q_patch,
    output logic                      fsm_enable,
    output logic                      sender_enable,
    output logic [INTERNAL_WIDTH-1:0] sender_data,
    output logic                      patch_en,
    output logic                      patch_two_en,
    output logic [PATCH_WIDTH-1:0]    patch_in,
    output logic [PATCH_WIDTH-1:0]    patch_in_two,
    input  logic [ADDRESS_WIDTH-1:0]  leaf_index,
    input  logic [ADDRESS_WIDTH-1:0]  leaf_index_two,
    input  logic                      receiver_en,
    input  logic                      receiver_two_en,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [ADDRESS_WIDTH-1:0]  res_leaf,
    output logic [TAG_WIDTH-1:0]      res_tag,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [31:0]               perf_cycles,
    output logic [31:0]               perf_stalls
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int NW = $clog2(NUM_NODES + 1);

    state_t state;
    logic [TAG_WIDTH-1:0] num_q, acc_cnt, buf_tag, tag_a, tag_b;
    logic [PATCH_WIDTH-1:0] buf_patch;
    logic [NW-1:0] node_cnt;
    logic [CW-1:0] in_flight, fifo_count;
    logic buf_v, credit_ok, accept, last, node_hs, pop;
    logic [1:0] issue_n;
    lane_tag_t pipe_a [TREE_LATENCY];
    lane_tag_t pipe_b [TREE_LATENCY];
    lane_tag_t out_a, out_b;
    result_t head;

    assign out_a = pipe_a[TREE_LATENCY-1];
    assign out_b = pipe_b[TREE_LATENCY-1];
    // Reserve room for a full pair so the non-stallable tree can always land its results.
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, in_flight} + (CW+1)'(2)) <= (CW+1)'(FIFO_DEPTH);
    assign q_ready = (state == S_QUERY) && (acc_cnt < num_q) && credit_ok;
    assign accept = q_valid && q_ready;
    assign last = ({1'b0, acc_cnt} + 1'b1) == {1'b0, num_q};
    assign issue_n = !accept ? 2'd0 : buf_v ? 2'd2 : last ? 2'd1 : 2'd0;
    assign node_ready = state == S_LOAD;
    assign fsm_enable = state == S_LOAD;
    assign node_hs = node_valid && node_ready;
    assign busy = state != S_IDLE;
    assign done = state == S_DONE;
    assign res_valid = fifo_count != '0;
    assign pop = res_valid && res_ready;
    assign res_leaf = res_valid ? head.leaf : '0;
    assign res_tag = res_valid ? head.tag : '0;

    kd_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push_a(receiver_en),
        .din_a ('{leaf: leaf_index, tag: out_a.tag}),
        .push_b(receiver_two_en),
        .din_b ('{leaf: leaf_index_two, tag: out_b.tag}),
        .pop   (pop),
        .dout  (head),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            num_q <= '0;
            acc_cnt <= '0;
            buf_v <= 1'b0;
            buf_patch <= '0;
            buf_tag <= '0;
            node_cnt <= '0;
            sender_enable <= 1'b0;
            sender_data <= '0;
            patch_en <= 1'b0;
            patch_two_en <= 1'b0;
            patch_in <= '0;
            patch_in_two <= '0;
            tag_a <= '0;
            tag_b <= '0;
            in_flight <= '0;
            error <= 1'b0;
        end else begin
            sender_enable <= node_hs;
            if (node_hs) begin
                sender_data <= node_data;
                node_cnt <= node_cnt + 1'b1;
            end
            patch_en <= 1'b0;
            patch_two_en <= 1'b0;
            in_flight <= in_flight + CW'(issue_n) - CW'(out_a.v) - CW'(out_b.v);
            if ((receiver_en != out_a.v) || (receiver_two_en != out_b.v)) error <= 1'b1;
            if (accept) begin
                acc_cnt <= acc_cnt + 1'b1;
                if (buf_v) begin
                    patch_en <= 1'b1;
                    patch_two_en <= 1'b1;
                    patch_in <= buf_patch;
                    patch_in_two <= q_patch;
                    tag_a <= buf_tag;
                    tag_b <= acc_cnt;
                    buf_v <= 1'b0;
                end else if (last) begin
                    patch_en <= 1'b1;
                    patch_in <= q_patch;
                    tag_a <= acc_cnt;
                end else begin
                    buf_v <= 1'b1;
                    buf_patch <= q_patch;
                    buf_tag <= acc_cnt;
                end
            end
            case (state)
                S_IDLE: if (start) begin
                    state <= skip_load ? S_QUERY : S_LOAD;
                    num_q <= num_queries;
                    acc_cnt <= '0;
                    node_cnt <= '0;
                    buf_v <= 1'b0;
                end
                S_LOAD: if (node_hs && node_cnt == NW'(NUM_NODES - 1)) state <= S_QUERY;
                S_QUERY: if (acc_cnt == num_q && !buf_v) state <= S_DRAIN;
                S_DRAIN: if (in_flight == '0 && fifo_count == '0) state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Tag pipe mirrors the tree latency and never stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < TREE_LATENCY; i++) begin
                pipe_a[i] <= '0;
                pipe_b[i] <= '0;
            end
        end else begin
            pipe_a[0] <= '{v: patch_en, tag: tag_a};
            pipe_b[0] <= '{v: patch_two_en, tag: tag_b};
            for (int i = 1; i < TREE_LATENCY; i++) begin
                pipe_a[i] <= pipe_a[i-1];
                pipe_b[i] <= pipe_b[i-1];
            end
        end
    end

`ifdef KD_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n || (state == S_IDLE && start)) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else begin
            if (state == S_QUERY || state == S_DRAIN) perf_cycles <= perf_cycles + 32'd1;
            if (state == S_QUERY && q_valid && !q_ready) perf_stalls <= perf_stalls + 32'd1;
        end
    end
`else
    assign perf_cycles = '0;
    assign perf_stalls = '0;
`endif
endmodule

// File: tb/tb_kd_query_scheduler.sv
// tb_kd_query_scheduler: table-driven jobs plus hand-written corner sequences, scoreboard on results.
module tb_kd_query_scheduler;
    localparam int L = 7;
    localparam int NN = 63;

    logic clk = 1'b0;
    logic rst_n, start, skip_load, node_valid, node_ready, q_valid, q_ready;
    logic [11:0] num_queries, res_tag;
    logic [21:0] node_data, sender_data;
    logic [54:0] q_patch, patch_in, patch_in_two;
    logic fsm_enable, sender_enable, patch_en, patch_two_en;
    logic [7:0] leaf_index, leaf_index_two, res_leaf;
    logic receiver_en, receiver_two_en, res_valid, res_ready, busy, done, error;
    logic [31:0] perf_cycles, perf_stalls;

    always #5 clk = ~clk;

    kd_query_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .skip_load(skip_load), .num_queries(num_queries),
        .node_valid(node_valid), .node_ready(node_ready), .node_data(node_data),
        .q_valid(q_valid), .q_ready(q_ready), .q_patch(q_patch),
        .fsm_enable(fsm_enable), .sender_enable(sender_enable), .sender_data(sender_data),
        .patch_en(patch_en), .patch_two_en(patch_two_en), .patch_in(patch_in), .patch_in_two(patch_in_two),
        .leaf_index(leaf_index), .leaf_index_two(leaf_index_two),
        .receiver_en(receiver_en), .receiver_two_en(receiver_two_en),
        .res_valid(res_valid), .res_ready(res_ready), .res_leaf(res_leaf), .res_tag(res_tag),
        .busy(busy), .done(done), .error(error), .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
    );

    int n_chk = 0, n_fail = 0;
    int se_cnt = 0, pair_cnt = 0, single_cnt = 0, done_cnt = 0, fsm_cyc = 0, res_cnt = 0, sent = 0;
    logic [21:0] nodes [NN];
    logic [19:0] sb [$];
    logic sb_on = 1'b1;
    logic drop_req = 1'b0;
    logic drop_done = 1'b0;

    typedef struct {
        logic skip;
        int nq;
        int pairs;
        int singles;
        int res;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] leaf_of(input logic [54:0] p);
        return p[7:0] ^ p[15:8];
    endfunction

    // Tree model: fixed-latency two-lane pipeline, optionally dropping one lane-B valid.
    logic [L-1:0] va, vb;
    logic [7:0] la [L];
    logic [7:0] lb [L];
    assign receiver_en = va[L-1];
    assign receiver_two_en = vb[L-1];
    assign leaf_index = la[L-1];
    assign leaf_index_two = lb[L-1];

    always @(posedge clk) begin
        if (!rst_n) begin
            va <= '0;
            vb <= '0;
        end else begin
            va <= {va[L-2:0], patch_en};
            vb <= {vb[L-2:0], patch_two_en && !(drop_req && !drop_done)};
            if (patch_two_en && drop_req && !drop_done) drop_done <= 1'b1;
            for (int i = L - 1; i > 0; i--) begin
                la[i] <= la[i-1];
                lb[i] <= lb[i-1];
            end
            la[0] <= leaf_of(patch_in);
            lb[0] <= leaf_of(patch_in_two);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (sender_enable) begin
                chk("sender_data", 64'(sender_data), 64'(nodes[se_cnt % NN]));
                se_cnt++;
            end
            if (patch_two_en) chk("lane_b_without_a", 64'(patch_en), 64'd1);
            if (patch_en && patch_two_en) pair_cnt++;
            if (patch_en && !patch_two_en) single_cnt++;
            if (done) done_cnt++;
            if (fsm_enable) fsm_cyc++;
        end
    end

    always @(negedge clk) begin
        #1;
        if (rst_n && res_valid && res_ready) begin
            res_cnt++;
            if (sb_on) begin
                if (sb.size() == 0) chk("res_unexpected", 64'(res_tag), 64'hFFFF);
                else begin
                    logic [19:0] e;
                    e = sb.pop_front();
                    chk("res_leaf", 64'(res_leaf), 64'(e[19:12]));
                    chk("res_tag", 64'(res_tag), 64'(e[11:0]));
                end
            end
        end
    end

    task automatic send_queries(input int nq);
        sent = 0;
        for (int i = 0; i < nq; i++) begin
            logic [54:0] p;
            int t;
            p = 55'({$urandom(), $urandom()});
            q_valid = 1'b1;
            q_patch = p;
            t = 0;
            #1;
            while (!q_ready && rst_n && t < 3000) begin
                @(negedge clk);
                #1;
                t++;
            end
            if (!rst_n) begin
                q_valid = 1'b0;
                return;
            end
            if (t >= 3000) begin
                chk("q_ready_timeout", 64'(t), 64'd0);
                q_valid = 1'b0;
                return;
            end
            sb.push_back({leaf_of(p), 12'(i)});
            sent++;
            @(negedge clk);
        end
        q_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int t = 0;
        while (!done && t < limit) begin
            @(negedge clk);
            t++;
        end
        if (t >= limit) chk("done_timeout", 64'(t), 64'd0);
    endtask

    task automatic start_job(input logic skip, input int nq);
        start = 1'b1;
        skip_load = skip;
        num_queries = 12'(nq);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        if (!skip) begin
            for (int i = 0; i < NN; i++) begin
                int t = 0;
                node_valid = 1'b1;
                node_data = nodes[i];
                #1;
                while (!node_ready && t < 100) begin
                    @(negedge clk);
                    #1;
                    t++;
                end
                if (t >= 100) chk("node_ready_timeout", 64'(t), 64'd0);
                @(negedge clk);
            end
            node_valid = 1'b0;
        end
    endtask

    task automatic run_job(input logic skip, input int nq, input int pairs, input int singles,
                           input int res, input logic exp_err);
        int p0, s0, r0, d0;
        p0 = pair_cnt; s0 = single_cnt; r0 = res_cnt; d0 = done_cnt;
        start_job(skip, nq);
        fork
            send_queries(nq);
        join_none
        wait_done(600);
        @(negedge clk);
        chk("busy_idle", 64'(busy), 64'd0);
        chk("pairs", 64'(pair_cnt - p0), 64'(pairs));
        chk("singles", 64'(single_cnt - s0), 64'(singles));
        chk("results", 64'(res_cnt - r0), 64'(res));
        chk("done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("error", 64'(error), 64'(exp_err));
        if (sb_on) chk("sb_left", 64'(sb.size()), 64'd0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_q_ready", 64'(q_ready), 64'd0);
        chk("rst_node_ready", 64'(node_ready), 64'd0);
        chk("rst_fsm_enable", 64'(fsm_enable), 64'd0);
        chk("rst_sender", 64'({sender_enable, sender_data}), 64'd0);
        chk("rst_patch_en", 64'({patch_en, patch_two_en}), 64'd0);
        chk("rst_patch_in", 64'(patch_in | patch_in_two), 64'd0);
        chk("rst_res_data", 64'({res_leaf, res_tag}), 64'd0);
        chk("rst_perf", 64'({perf_cycles, perf_stalls}), 64'd0);
    endtask

    initial begin
        int se0, fc0;
        rst_n = 1'b0; start = 1'b0; skip_load = 1'b0; num_queries = '0;
        node_valid = 1'b0; node_data = '0; q_valid = 1'b0; q_patch = '0; res_ready = 1'b1;
        for (int i = 0; i < NN; i++) nodes[i] = 22'($urandom());
        vecs[0] = '{1'b1, 4, 2, 0, 4};
        vecs[1] = '{1'b1, 3, 1, 1, 3};
        vecs[2] = '{1'b1, 0, 0, 0, 0};
        vecs[3] = '{1'b1, 1, 0, 1, 1};
        vecs[4] = '{1'b1, 9, 4, 1, 9};
        vecs[5] = '{1'b0, 2, 1, 0, 2};
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);

        se0 = se_cnt; fc0 = fsm_cyc;
        run_job(1'b0, 4, 2, 0, 4, 1'b0);
        chk("load_pulses", 64'(se_cnt - se0), 64'(NN));
        chk("load_fsm_cycles", 64'(fsm_cyc - fc0), 64'(NN));

        for (int v = 0; v < 6; v++)
            run_job(vecs[v].skip, vecs[v].nq, vecs[v].pairs, vecs[v].singles, vecs[v].res, 1'b0);

        begin
            int r0;
            r0 = res_cnt;
            res_ready = 1'b0;
            start_job(1'b1, 40);
            fork
                send_queries(40);
            join_none
            repeat (80) @(negedge clk);
            #1;
            chk("bp_accepted", 64'(sent), 64'd16);
            chk("bp_q_ready", 64'(q_ready), 64'd0);
            chk("bp_res_valid", 64'(res_valid), 64'd1);
            res_ready = 1'b1;
            wait_done(1000);
            @(negedge clk);
            chk("bp_results", 64'(res_cnt - r0), 64'd40);
            chk("bp_sb_left", 64'(sb.size()), 64'd0);
            chk("bp_error", 64'(error), 64'd0);
        end

        sb_on = 1'b0;
        drop_req = 1'b1;
        run_job(1'b1, 4, 2, 0, 3, 1'b1);
        sb.delete();
        sb_on = 1'b1;
        run_job(1'b1, 2, 1, 0, 2, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("error_cleared", 64'(error), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        start_job(1'b1, 10);
        fork
            send_queries(10);
        join_none
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs();
        sb.delete();
        rst_n = 1'b1;
        @(negedge clk);
        run_job(1'b1, 4, 2, 0, 4, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
